perm_rom_sequencer: RTL and testbench

- Controller for the 128x5 permutation-index ROM (4 banks of 32 entries, registered read, 1-cycle latency, no read enable).
- On a start command, the block walks all 32 addresses of one selected bank and drives the ROM address.
- It compensates for the ROM read latency and streams the resulting 5-bit indices to a downstream consumer over a valid/ready handshake with full backpressure.
- It sits between the transform-stage controller (start/stage/done) and the coefficient-buffer address logic (index stream).

---
 rtl/perm_rom_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_perm_rom_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/perm_rom_sequencer.sv
// perm_rom_sequencer
// Walks the 32 entries of one bank of the permutation-index ROM, hides the
// one-cycle registered-read latency and streams the indices over a
// valid/ready interface. A two-entry skid FIFO absorbs backpressure. Its head
// register drives idx_data/idx_last directly, so those outputs are registered.
module perm_rom_sequencer #(
   parameter int DATA_WIDTH = 5,
   parameter int ADDR_WIDTH = 7,
   parameter int BANK_BITS  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BANK_BITS-1:0]  stage,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   output logic                  rom_wr_ena,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic                  idx_valid,
   input  logic                  idx_ready,
   output logic [DATA_WIDTH-1:0] idx_data,
   output logic                  idx_last
);

   localparam int CNT_WIDTH = ADDR_WIDTH - BANK_BITS;
   localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                 state_r;
   logic [BANK_BITS-1:0]   bank_r;
   logic [CNT_WIDTH-1:0]   issue_cnt_r;
   logic [ADDR_WIDTH-1:0]  rom_addr_r;
   logic                   inflight_r;       // rom_data holds a requested word this cycle
   logic                   inflight_last_r;  // ...and it is the 32nd word of the run
   logic                   head_valid_r;
   logic [DATA_WIDTH-1:0]  head_data_r;
   logic                   head_last_r;
   logic                   skid_valid_r;
   logic [DATA_WIDTH-1:0]  skid_data_r;
   logic                   skid_last_r;
   logic                   busy_r;
   logic                   done_r;

   logic                   pop_s;
   logic [1:0]             occ_s;
   logic [1:0]             load_s;
   logic                   issue_s;

   assign rom_wr_ena = 1'b0;
   assign rom_addr   = rom_addr_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign idx_valid  = head_valid_r;
   assign idx_data   = head_data_r;
   assign idx_last   = head_last_r;

   // Handshake, post-pop occupancy and issue decision for this cycle
   always_comb begin
      pop_s   = head_valid_r & idx_ready;
      occ_s   = {1'b0, head_valid_r} + {1'b0, skid_valid_r} - {1'b0, pop_s};
      load_s  = occ_s + {1'b0, inflight_r};
      issue_s = 1'b0;
      if ((state_r == RUN) && (load_s < 2'd2)) begin
         issue_s = 1'b1;
      end else begin
         issue_s = 1'b0;
      end
   end

   // Control FSM, address generator, read pipeline flag and skid FIFO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r         <= IDLE;
         bank_r          <= {BANK_BITS{1'b0}};
         issue_cnt_r     <= CNT_ZERO;
         rom_addr_r      <= ADDR_ZERO;
         inflight_r      <= 1'b0;
         inflight_last_r <= 1'b0;
         head_valid_r    <= 1'b0;
         head_data_r     <= DATA_ZERO;
         head_last_r     <= 1'b0;
         skid_valid_r    <= 1'b0;
         skid_data_r     <= DATA_ZERO;
         skid_last_r     <= 1'b0;
         busy_r          <= 1'b0;
         done_r          <= 1'b0;
      end else if (abort && (state_r != IDLE)) begin
         // Flush everything in flight; the aborted run never reports done.
         state_r         <= IDLE;
         inflight_r      <= 1'b0;
         inflight_last_r <= 1'b0;
         head_valid_r    <= 1'b0;
         head_last_r     <= 1'b0;
         skid_valid_r    <= 1'b0;
         skid_last_r     <= 1'b0;
         busy_r          <= 1'b0;
         done_r          <= 1'b0;
      end else begin
         // The word read at this edge appears on rom_data next cycle.
         inflight_r      <= issue_s;
         inflight_last_r <= issue_s && (issue_cnt_r == CNT_MAX);

         // Skid FIFO: head feeds the outputs, skid holds the overflow word.
         if (pop_s) begin
            if (skid_valid_r) begin
               head_data_r <= skid_data_r;
               head_last_r <= skid_last_r;
               if (inflight_r) begin
                  skid_data_r <= rom_data;
                  skid_last_r <= inflight_last_r;
               end else begin
                  skid_valid_r <= 1'b0;
                  skid_last_r  <= 1'b0;
               end
            end else if (inflight_r) begin
               head_data_r <= rom_data;
               head_last_r <= inflight_last_r;
            end else begin
               head_valid_r <= 1'b0;
               head_last_r  <= 1'b0;
            end
         end else if (inflight_r) begin
            if (head_valid_r) begin
               skid_valid_r <= 1'b1;
               skid_data_r  <= rom_data;
               skid_last_r  <= inflight_last_r;
            end else begin
               head_valid_r <= 1'b1;
               head_data_r  <= rom_data;
               head_last_r  <= inflight_last_r;
            end
         end

         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  bank_r      <= stage;
                  issue_cnt_r <= CNT_ZERO;
                  rom_addr_r  <= {stage, CNT_ZERO};
                  busy_r      <= 1'b1;
                  state_r     <= RUN;
               end
            end
            RUN: begin
               if (issue_s) begin
                  if (issue_cnt_r == CNT_MAX) begin
                     // Final address issued: hold it, never step into the next bank.
                     state_r <= DRAIN;
                  end else begin
                     issue_cnt_r <= issue_cnt_r + CNT_ONE;
                     rom_addr_r  <= {bank_r, issue_cnt_r + CNT_ONE};
                  end
               end
            end
            DRAIN: begin
               if (pop_s && head_last_r) begin
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_perm_rom_sequencer.sv
// Directed testbench for perm_rom_sequencer with a behavioural 128x5 ROM.
module tb_perm_rom_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [1:0] stage;
   logic       abort;
   logic       busy;
   logic       done;
   logic [6:0] rom_addr;
   logic       rom_wr_ena;
   logic [4:0] rom_data;
   logic       idx_valid;
   logic       idx_ready;
   logic [4:0] idx_data;
   logic       idx_last;

   logic [4:0] rom_mem [128];
   logic [4:0] exp_seq [32];
   logic [4:0] exp_b1 [32] = '{5'd0, 5'd2, 5'd4, 5'd6, 5'd1, 5'd3, 5'd5, 5'd7,
                               5'd8, 5'd10, 5'd12, 5'd14, 5'd9, 5'd11, 5'd13, 5'd15,
                               5'd16, 5'd18, 5'd20, 5'd22, 5'd17, 5'd19, 5'd21, 5'd23,
                               5'd24, 5'd26, 5'd28, 5'd30, 5'd25, 5'd27, 5'd29, 5'd31};
   logic [4:0] exp_b2 [32] = '{5'd0, 5'd8, 5'd16, 5'd24, 5'd1, 5'd9, 5'd17, 5'd25,
                               5'd2, 5'd10, 5'd18, 5'd26, 5'd3, 5'd11, 5'd19, 5'd27,
                               5'd4, 5'd12, 5'd20, 5'd28, 5'd5, 5'd13, 5'd21, 5'd29,
                               5'd6, 5'd14, 5'd22, 5'd30, 5'd7, 5'd15, 5'd23, 5'd31};

   int checks = 0;
   int errors = 0;

   perm_rom_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stage      (stage),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .rom_addr   (rom_addr),
      .rom_wr_ena (rom_wr_ena),
      .rom_data   (rom_data),
      .idx_valid  (idx_valid),
      .idx_ready  (idx_ready),
      .idx_data   (idx_data),
      .idx_last   (idx_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-read ROM, one cycle latency
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic load_identity();
      for (int i = 0; i < 32; i++) exp_seq[i] = 5'(i);
   endtask

   // Called at a negedge in IDLE; returns at the negedge after the accepting edge
   task automatic do_start(input logic [1:0] stg, input logic ab);
      start = 1'b1;
      stage = stg;
      abort = ab;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("start_busy", busy, 1);
      check("start_addr", rom_addr, {stg, 5'd0});
      check("start_valid", idx_valid, 0);
   endtask

   // mode 0: ready=1; mode 1: ready pattern 1,0,0,1; mode 2: ready=0 for 10 cycles
   // stop_kind 0: run to done; otherwise return when index stop_at is pending
   task automatic run_stream(input logic [1:0] stg, input int mode, input int stop_at,
                             input int stop_kind, input string name);
      int cyc, n, first_valid, viol, off;
      logic prev_stall, prev_last, rdy;
      logic [4:0] prev_data;
      bit finished;
      cyc = 0; n = 0; first_valid = -1; viol = 0;
      prev_stall = 1'b0; prev_last = 1'b0; prev_data = 5'd0; finished = 1'b0;
      while (!finished && cyc < 300) begin
         if (rom_addr[6:5] !== stg) viol++;
         off = int'(rom_addr[4:0]);
         if (off > n + 2) viol++;
         if (prev_stall) begin
            check({name, "_stall_valid"}, idx_valid, 1);
            check({name, "_stall_data"}, idx_data, prev_data);
            check({name, "_stall_last"}, idx_last, prev_last);
         end
         if (idx_valid && first_valid < 0) first_valid = cyc;
         if (done) begin
            check({name, "_count"}, n, 32);
            check({name, "_first_valid"}, first_valid, 2);
            if (mode == 0) check({name, "_done_cycle"}, cyc, 34);
            check({name, "_addr_window"}, viol, 0);
            check({name, "_busy_in_done"}, busy, 1);
            finished = 1'b1;
         end else if (stop_kind != 0 && n == stop_at && idx_valid) begin
            check({name, "_pending_data"}, idx_data, exp_seq[n]);
            finished = 1'b1;
         end else begin
            case (mode)
               1: rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
               2: rdy = (cyc >= 10);
               default: rdy = 1'b1;
            endcase
            if (mode == 2 && cyc == 9) check({name, "_frozen_addr"}, rom_addr, {stg, 5'd2});
            if (mode == 1 && cyc == 5) begin
               start = 1'b1;
               stage = ~stg;
            end
            if (mode == 1 && cyc == 6) start = 1'b0;
            if (idx_valid && rdy) begin
               if (n < 32) begin
                  check({name, "_data"}, idx_data, exp_seq[n]);
                  check({name, "_last"}, idx_last, (n == 31));
               end else begin
                  check({name, "_extra_index"}, 1, 0);
               end
               n++;
            end
            prev_stall = idx_valid && !rdy;
            prev_data  = idx_data;
            prev_last  = idx_last;
            idx_ready  = rdy;
            @(negedge clk);
            cyc++;
         end
      end
      check({name, "_timeout"}, finished, 1);
   endtask

   initial begin
      int v;
      for (int a = 0; a < 128; a++) begin
         int i;
         i = a % 32;
         case (a / 32)
            1: v = (i / 8) * 8 + (((i % 8) < 4) ? 2 * (i % 8) : 2 * ((i % 8) - 4) + 1);
            2: v = (i % 4) * 8 + i / 4;
            default: v = i;
         endcase
         rom_mem[a] = 5'(v);
      end

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; stage = 2'd0; idx_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_addr", rom_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", idx_valid, 0);
      check("rst_data", idx_data, 0);
      check("rst_last", idx_last, 0);
      check("rst_wr_ena", rom_wr_ena, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", busy, 0);

      // Stage 0, free-flowing consumer
      load_identity();
      do_start(2'd0, 1'b0);
      run_stream(2'd0, 0, 0, 0, "s0");
      @(negedge clk);
      check("s0_done_once", done, 0);
      check("s0_busy_after", busy, 0);

      // Stage 1, then start held from the DONE cycle into the first IDLE cycle
      exp_seq = exp_b1;
      do_start(2'd1, 1'b0);
      run_stream(2'd1, 0, 0, 0, "s1");
      start = 1'b1;
      stage = 2'd2;
      @(negedge clk);
      check("done_start_ignored", busy, 0);
      check("s1_done_once", done, 0);
      @(negedge clk);
      start = 1'b0;
      check("idle_start_busy", busy, 1);
      check("idle_start_addr", rom_addr, {2'd2, 5'd0});

      // Stage 2 with toggling ready and a start/stage poke while busy
      exp_seq = exp_b2;
      run_stream(2'd2, 1, 0, 0, "s2");
      @(negedge clk);
      check("s2_done_once", done, 0);

      // Consumer stalled for 10 cycles after start
      exp_seq = exp_b1;
      do_start(2'd1, 1'b0);
      run_stream(2'd1, 2, 0, 0, "stall");
      @(negedge clk);
      check("stall_done_once", done, 0);

      // Abort while the 10th index is pending
      load_identity();
      do_start(2'd0, 1'b0);
      run_stream(2'd0, 0, 9, 1, "abort");
      idx_ready = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_valid", idx_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      repeat (3) begin
         @(negedge clk);
         check("abort_no_done", done, 0);
      end

      // Start together with abort in IDLE: start wins
      do_start(2'd3, 1'b1);
      run_stream(2'd3, 0, 0, 0, "s3");
      @(negedge clk);
      check("s3_done_once", done, 0);

      // Asynchronous reset in the middle of a run
      exp_seq = exp_b2;
      do_start(2'd2, 1'b0);
      run_stream(2'd2, 0, 12, 2, "rstmid");
      idx_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmid_valid", idx_valid, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_done", done, 0);
      check("rstmid_addr", rom_addr, 0);
      check("rstmid_data", idx_data, 0);
      check("rstmid_last", idx_last, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rstmid_idle_done", done, 0);

      load_identity();
      do_start(2'd0, 1'b0);
      run_stream(2'd0, 0, 0, 0, "post_rst");
      @(negedge clk);
      check("post_rst_done_once", done, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
